// File: rtl/contador_garrafas_duzias_pkg.sv
// Shared constants and helpers for the bottle/dozen counting stage.
// Holds the lote FSM encoding, default batch constants and BCD helpers,
// so the dozen FSM and this stage agree on the same numbers.
package contador_garrafas_duzias_pkg;

  localparam int unsigned GARRAFAS_W              = 4;
  localparam int unsigned DUZIAS_W                = 8;
  localparam int unsigned GARRAFAS_POR_DUZIA_DFLT = 12;
  localparam int unsigned MAX_DUZIAS_DFLT         = 10;

  typedef enum logic [1:0] {
    LOTE_RUN    = 2'b00,
    LOTE_CHEIO  = 2'b01,
    LOTE_LIBERA = 2'b10
  } lote_state_t;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd9) begin
      u = 4'd0;
      t = (t == 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  // Binary (0..99) to two-digit BCD, used for elaboration-time constants.
  function automatic logic [7:0] to_bcd(input int unsigned n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/contador_garrafas_duzias_if.sv
// Interface between the dozen FSM / operator panel (master) and the
// counting stage (slave).
//   cont1, add_cont12, lote_ack          : master -> slave
//   cont12, garrafas, duzias_bcd,
//   lote_cheio, parar_esteira, erro_overflow : slave -> master
interface contador_garrafas_duzias_if;

  logic                                               cont1;
  logic                                               add_cont12;
  logic                                               lote_ack;
  logic                                               cont12;
  logic [contador_garrafas_duzias_pkg::GARRAFAS_W-1:0] garrafas;
  logic [contador_garrafas_duzias_pkg::DUZIAS_W-1:0]   duzias_bcd;
  logic                                               lote_cheio;
  logic                                               parar_esteira;
  logic                                               erro_overflow;

  modport master (
    output cont1, add_cont12, lote_ack,
    input  cont12, garrafas, duzias_bcd, lote_cheio, parar_esteira, erro_overflow
  );

  modport slave (
    input  cont1, add_cont12, lote_ack,
    output cont12, garrafas, duzias_bcd, lote_cheio, parar_esteira, erro_overflow
  );

endinterface

// File: rtl/contador_garrafas_duzias_bcd_2dig.sv
// Two-digit BCD dozen counter; clear has priority over increment.
// Ports: clk, reset (async, active-high), i_inc, i_clr, o_bcd[7:0].
module contador_bcd_2dig
  import contador_garrafas_duzias_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [7:0] o_bcd
);

  logic [7:0] r_bcd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd <= 8'h00;
    end else if (i_clr) begin
      r_bcd <= 8'h00;
    end else if (i_inc) begin
      r_bcd <= bcd_inc(r_bcd);
    end
  end

  assign o_bcd = r_bcd;

endmodule

// File: rtl/contador_garrafas_duzias.sv
// Bottle/dozen counting stage behind the dozen FSM.
// Counts cont1 pulses into garrafas, returns cont12, consumes add_cont12
// edges into a BCD dozen count and stops the conveyor once a batch is full
// until the operator acknowledge handshake completes.
// Ports: clk, reset (async, active-high), bus (slave modport).
module contador_garrafas_duzias
  import contador_garrafas_duzias_pkg::*;
#(
  parameter int unsigned GARRAFAS_POR_DUZIA = GARRAFAS_POR_DUZIA_DFLT,
  parameter int unsigned MAX_DUZIAS         = MAX_DUZIAS_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  contador_garrafas_duzias_if.slave  bus
);

  localparam logic [GARRAFAS_W-1:0] GPD     = GARRAFAS_W'(GARRAFAS_POR_DUZIA);
  localparam logic [DUZIAS_W-1:0]   MAX_BCD = to_bcd(MAX_DUZIAS);

  logic                  r_add_q;
  logic [GARRAFAS_W-1:0] r_garrafas;
  logic                  r_erro;
  lote_state_t           r_state;

  logic                  w_add_ev;
  logic                  w_run;
  logic                  w_cont12;
  logic                  w_inc;
  logic                  w_clr;
  logic [DUZIAS_W-1:0]   w_duzias;

  assign w_add_ev = bus.add_cont12 & ~r_add_q;
  assign w_run    = (r_state == LOTE_RUN);
  assign w_cont12 = (r_garrafas == GPD);
  // A dozen is only consumed while running and actually complete.
  assign w_inc    = w_run & w_add_ev & w_cont12;
  assign w_clr    = (r_state == LOTE_CHEIO) & bus.lote_ack;

  // Unit bottle counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_q    <= 1'b0;
      r_garrafas <= '0;
      r_erro     <= 1'b0;
    end else begin
      r_add_q <= bus.add_cont12;
      if (!w_run) begin
        if (bus.cont1) r_erro <= 1'b1;
      end else if (w_add_ev && w_cont12) begin
        // Keep a bottle that lands on the same edge as the consume.
        r_garrafas <= bus.cont1 ? GARRAFAS_W'(1) : '0;
      end else if (bus.cont1) begin
        if (!w_cont12) r_garrafas <= r_garrafas + GARRAFAS_W'(1);
        else           r_erro     <= 1'b1;
      end
    end
  end

  contador_bcd_2dig u_duzias (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_bcd (w_duzias)
  );

  // Batch FSM: full on the edge the dozen count reaches MAX, released by ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= LOTE_RUN;
    end else begin
      case (r_state)
        LOTE_RUN:    if (w_inc && (bcd_inc(w_duzias) == MAX_BCD)) r_state <= LOTE_CHEIO;
        LOTE_CHEIO:  if (bus.lote_ack)  r_state <= LOTE_LIBERA;
        LOTE_LIBERA: if (!bus.lote_ack) r_state <= LOTE_RUN;
        default:     r_state <= LOTE_RUN;
      endcase
    end
  end

  assign bus.cont12        = w_cont12;
  assign bus.garrafas      = r_garrafas;
  assign bus.duzias_bcd    = w_duzias;
  assign bus.lote_cheio    = (r_state == LOTE_CHEIO);
  assign bus.parar_esteira = (r_state == LOTE_CHEIO) | (r_state == LOTE_LIBERA);
  assign bus.erro_overflow = r_erro;

endmodule
